pipe_int_ctrl: RTL
==================

Name: pipe_int_ctrl

Overview:
- Front-end pipeline controller for the 5-stage core. Generates the control inputs of the IF/ID register: IF_IDWrite, IF_Flush, INT_detected, INT_restore.
- Also generates PC write enable, PC source select and the ID/EX bubble.
- Sequences load-use stalls, taken-branch flushes, masked prioritised interrupt entry and ERET return (EPC/restore).

Parameters:
- N_IRQ, 4, number of interrupt sources; index 0 is highest priority.
- VEC_BASE, 32'h0000_0800, handler vector for source 0.
- VEC_STRIDE, 32'h0000_0020, vector spacing per source index.
- MASK_RST, {N_IRQ{1'b1}}, irq_mask value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_src  in  N_IRQ  level interrupt lines, rising-edge sensitive
- irq_mask_we  in  1  load irq_mask
- irq_mask_wdata  in  N_IRQ  new mask; 1 = enabled
- IF_PC  in  32  PC of the instruction currently in IF
- ID_rs  in  5  rs of the instruction in ID
- ID_rt  in  5  rt of the instruction in ID
- ID_eret  in  1  instruction in ID is ERET
- EX_MemRead  in  1  EX-stage instruction is a load
- EX_rt  in  5  load destination register
- branch_taken  in  1  branch/jump resolved taken in EX
- PCWrite  out  1  PC register enable
- pc_sel  out  2  00 sequential/branch (datapath mux), 01 int_vector, 10 epc
- IF_IDWrite  out  1  IF/ID enable
- IF_Flush  out  1  clear IF/ID
- ID_EX_Flush  out  1  insert bubble into ID/EX
- INT_detected  out  1  IF/ID backs up its contents and clears
- INT_restore  out  1  IF/ID reloads its backup
- int_vector  out  32  handler address
- epc  out  32  saved return PC
- int_cause  out  $clog2(N_IRQ)  index of the serviced source
- in_handler  out  1  FSM is in HANDLER
- irq_mask  out  N_IRQ  current mask

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, pending=0, irq_mask=MASK_RST, epc=0, int_cause=0, irq_prev=0.
- Combinational outputs during reset: PCWrite=0, IF_IDWrite=0, IF_Flush=1, ID_EX_Flush=1, INT_detected=0, INT_restore=0, pc_sel=00.
- Pending register:
  - pending[i] is set when irq_src[i] is 1 and irq_prev[i] was 0.
  - pending[i] is cleared on the take cycle when i is serviced.
  - A simultaneous new edge on i wins and pending[i] stays set.
  - Masked sources still latch pending.
- Priority: sel = lowest i with pending[i] & irq_mask[i]. int_vector = VEC_BASE + sel*VEC_STRIDE, computed as 32-bit with wrap.
- stall = EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || EX_rt==ID_rt).
- Outputs are combinational from state and inputs. Action priority per cycle, highest first:
  1. branch_taken: PCWrite=1, pc_sel=00, IF_Flush=1, ID_EX_Flush=1, IF_IDWrite=0. Any take/return is deferred.
  2. stall: PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1. Any take/return is deferred.
  3. take (state IDLE, any enabled pending):
     - Outputs: INT_detected=1, PCWrite=1, pc_sel=01, ID_EX_Flush=1, IF_IDWrite=0.
     - At the edge: epc<=IF_PC, int_cause<=sel, pending[sel] cleared, state->HANDLER.
  4. return (state HANDLER, ID_eret=1):
     - Outputs: INT_restore=1, PCWrite=1, pc_sel=10, ID_EX_Flush=1 (ERET squashed), IF_IDWrite=0.
     - At the edge: state->IDLE.
  5. Otherwise: PCWrite=1, IF_IDWrite=1, pc_sel=00, all flushes 0.
- Timing:
  - An irq edge sampled at edge N makes the take possible in cycle N+1, so minimum latency is 1 cycle.
  - In HANDLER no new take occurs (no nesting); pending keeps accumulating.
  - ID_eret in IDLE is ignored and behaves as row 5.
- irq_mask_we applies at the edge. A write in the same cycle as a take does not affect that take.
- reset mid-HANDLER returns to IDLE; epc and the backup are lost.
- in_handler = (state==HANDLER).

Decomposition:
- Shared package pipe_ctrl_pkg:
  - pc_sel encodings PCSEL_SEQ/PCSEL_VEC/PCSEL_EPC
  - state enum IDLE/HANDLER
  - default VEC_BASE and VEC_STRIDE
- One sub-module: irq_prio_enc, a parameterised pending-AND-mask priority encoder producing valid and index.

Test Plan:
- Reset held 2 cycles -> IF_Flush=1, PCWrite=0, irq_mask=4'hF, in_handler=0. First cycle after release: PCWrite=1, IF_IDWrite=1.
- EX_MemRead=1, EX_rt=5, ID_rs=5 -> PCWrite=0, IF_IDWrite=0, ID_EX_Flush=1 that cycle. Same with EX_rt=0 -> no stall.
- irq_src=4'b0110, IF_PC=32'h100 -> next cycle INT_detected=1, pc_sel=01, int_vector=32'h820. After the edge: epc=32'h100, int_cause=1, pending=4'b0100.
- In HANDLER with ID_eret=1 -> INT_restore=1, pc_sel=10, epc=32'h100. Next cycle state IDLE, then take source 2 with vector 32'h840.
- Pending source 0 with branch_taken=1 -> IF_Flush=1, INT_detected=0. Next cycle with no branch -> INT_detected=1.
- Mask write 4'b1110 then irq_src[0] edge -> no take. Mask write 4'hF -> take with int_cause=0. Reset asserted in HANDLER -> in_handler=0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared encodings and defaults for the front-end pipeline controller
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_EPC = 2'b10;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0020;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Masked priority encoder, lowest set index wins
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_pending,
    input  logic [N-1:0]     i_mask,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index
);

    logic [N-1:0] w_req;

    assign w_req = i_pending & i_mask;

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                o_valid = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_int_ctrl
// Purpose  : IF/ID/PC control: load-use stall, branch flush, interrupt entry/ERET
// Revision : 1.0 - initial release
// ============================================================================
module pipe_int_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int               N_IRQ      = 4,
    parameter logic [31:0]      VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0]      VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [N_IRQ-1:0] MASK_RST   = {N_IRQ{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IRQ-1:0]         irq_src,
    input  logic                     irq_mask_we,
    input  logic [N_IRQ-1:0]         irq_mask_wdata,
    input  logic [31:0]              IF_PC,
    input  logic [4:0]               ID_rs,
    input  logic [4:0]               ID_rt,
    input  logic                     ID_eret,
    input  logic                     EX_MemRead,
    input  logic [4:0]               EX_rt,
    input  logic                     branch_taken,
    output logic                     PCWrite,
    output logic [1:0]               pc_sel,
    output logic                     IF_IDWrite,
    output logic                     IF_Flush,
    output logic                     ID_EX_Flush,
    output logic                     INT_detected,
    output logic                     INT_restore,
    output logic [31:0]              int_vector,
    output logic [31:0]              epc,
    output logic [$clog2(N_IRQ)-1:0] int_cause,
    output logic                     in_handler,
    output logic [N_IRQ-1:0]         irq_mask
);

    localparam int               c_idx_w = $clog2(N_IRQ);
    localparam logic [N_IRQ-1:0] c_one   = N_IRQ'(1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;
    logic [N_IRQ-1:0]     r_pending;
    logic [N_IRQ-1:0]     r_irq_prev;
    logic [N_IRQ-1:0]     r_irq_mask;
    logic [31:0]          r_epc;
    logic [c_idx_w-1:0]   r_int_cause;

    logic                 w_valid;
    logic [c_idx_w-1:0]   w_sel;
    logic                 w_stall;
    logic                 w_take;
    logic [N_IRQ-1:0]     w_clr;

    irq_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (c_idx_w)
    ) u_prio (
        .i_pending (r_pending),
        .i_mask    (r_irq_mask),
        .o_valid   (w_valid),
        .o_index   (w_sel)
    );

    assign w_stall = EX_MemRead && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (EX_rt == ID_rt));

    assign int_vector = VEC_BASE + (32'(w_sel) * VEC_STRIDE);
    assign w_clr      = w_take ? (c_one << w_sel) : '0;
    assign epc        = r_epc;
    assign int_cause  = r_int_cause;
    assign irq_mask   = r_irq_mask;
    assign in_handler = (r_state == HANDLER);

    always_comb begin
        PCWrite      = 1'b1;
        pc_sel       = PCSEL_SEQ;
        IF_IDWrite   = 1'b1;
        IF_Flush     = 1'b0;
        ID_EX_Flush  = 1'b0;
        INT_detected = 1'b0;
        INT_restore  = 1'b0;
        w_take       = 1'b0;
        w_state_nxt  = r_state;
        if (reset) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            IF_Flush    = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (branch_taken) begin
            IF_IDWrite  = 1'b0;
            IF_Flush    = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_stall) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if ((r_state == IDLE) && w_valid) begin
            INT_detected = 1'b1;
            pc_sel       = PCSEL_VEC;
            IF_IDWrite   = 1'b0;
            ID_EX_Flush  = 1'b1;
            w_take       = 1'b1;
            w_state_nxt  = HANDLER;
        end else if ((r_state == HANDLER) && ID_eret) begin
            // The ERET itself is squashed; IF/ID restores the backed-up word.
            INT_restore = 1'b1;
            pc_sel      = PCSEL_EPC;
            IF_IDWrite  = 1'b0;
            ID_EX_Flush = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_irq_prev  <= '0;
            r_irq_mask  <= MASK_RST;
            r_epc       <= '0;
            r_int_cause <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_prev <= irq_src;
            // A fresh edge on the serviced source overrides its clear.
            r_pending  <= (r_pending & ~w_clr) | (irq_src & ~r_irq_prev);
            if (irq_mask_we) begin
                r_irq_mask <= irq_mask_wdata;
            end
            if (w_take) begin
                r_epc       <= IF_PC;
                r_int_cause <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire
